serial_rx_sync: RTL and testbench
=================================

# serial_rx_sync

Receive-side serial-to-parallel converter with comma (0xBC) alignment for one PHY lane. It shifts in a 1-bit serial stream, finds byte alignment on the 0xBC comma character, and declares the lane synchronized after `SYNC_COUNT` consecutive aligned commas. It then delivers parallel bytes with a valid flag and drives `IDL`, the enable that gates lane data into the L1 byte paths.

## Interface
- `BC_CHAR`, default 8'hBC: comma/idle character.
- `SYNC_COUNT`, default 4: consecutive aligned commas required to declare sync, range 1..7.
- `clk` input 1: bit clock; the single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `data_in` input 1: serial bit, MSB first, sampled every `clk` rising edge.
- `data_out` output 8: last received non-comma byte; held between updates.
- `valid_out` output 1: 1 while `data_out` holds a data byte from the current byte slot; 0 for a comma slot.
- `byte_stb` output 1: one-cycle pulse when `data_out`/`valid_out` update, only in SYNC.
- `IDL` output 1: 1 = lane synchronized and data may pass; 0 = blocked.

## Operation
- Shift register: `nxt = {sr[6:0], data_in}`; `sr <= nxt` every cycle.
- 3-bit bit counter `bcnt`; 0..`SYNC_COUNT` comma counter `ccnt`.
- States: SEARCH, ALIGN, SYNC. Encoding lives in the shared header.
- SEARCH:
  - Compares `nxt` with `BC_CHAR` every cycle, at any bit offset.
  - On match: `bcnt <= 0`, `ccnt <= 1`, then go to ALIGN; if `SYNC_COUNT` == 1, go directly to SYNC instead.
- ALIGN:
  - `bcnt` increments and wraps 7 -> 0.
  - A boundary is a cycle with `bcnt` == 7; `nxt` is the completed byte.
  - On a boundary: if `nxt` == `BC_CHAR`, `ccnt` increments; reaching `SYNC_COUNT` moves to SYNC.
  - On a boundary with any other byte: `ccnt <= 0`, return to SEARCH. The bits of that byte are not reused for the same-cycle match.
- SYNC:
  - On each boundary, `byte_stb` pulses.
  - Non-comma byte: `data_out <= nxt`, `valid_out <= 1`.
  - Comma byte: `valid_out <= 0`, `data_out` holds its previous value.
- SYNC is left only on `reset`; there is no loss-of-sync detection in this revision.
- `IDL` = 1 exactly while in SYNC, and is registered.

## Timing
- Reset values: `data_out` = 8'h00, `valid_out` = 0, `byte_stb` = 0, `IDL` = 0, state SEARCH, `sr` = 0, `bcnt` = 0, `ccnt` = 0.
- Latency: the last bit of a byte is present on `data_in` at edge N. `data_out`, `valid_out`, `byte_stb` and `IDL` reflect it after edge N and are visible in cycle N+1.
- `byte_stb` is high for exactly 1 of every 8 cycles in SYNC and 0 elsewhere.
- `IDL` rises after the edge that completes the `SYNC_COUNT`-th comma. The first `byte_stb` occurs 8 cycles later.
- `reset` asserted mid-byte forces all outputs to reset values asynchronously. Alignment restarts from SEARCH after deassertion.
- Partial match followed by a mismatch in SEARCH has no effect; detection is purely the 8-bit window compare.

## Structure
- Shared header `phy_defs.vh`: `BC_CHAR` default value and the state encodings `ST_SEARCH`=2'd0, `ST_ALIGN`=2'd1, `ST_SYNC`=2'd2.
- Single flat module: one sequential block for registers, one combinational block for next-state.
- No sub-module.
- Four-lane use means four instances; the `IDL` outputs are ANDed at the PHY top.

## Test plan
- Reset check: `reset`=1 with random `data_in` -> all outputs 0. Deassert reset, send 32 bits of 0 -> `IDL`=0, `byte_stb` never pulses.
- Sync acquisition: 3 junk bits, then 4×0xBC, then 0x55 -> `IDL`=1 one cycle after the 32nd comma bit. 8 cycles later `byte_stb`=1, `data_out`=0x55, `valid_out`=1.
- Sync abort: 2×0xBC, 0xA3, 4×0xBC -> `IDL` stays 0 through the first 24 bits and rises only after the final 4 commas.
- Data/idle interleave in SYNC: 0x12, 0xBC, 0x34 -> three strobes. Values are (`data_out`, `valid_out`) = (0x12, 1), (0x12, 0), (0x34, 1).
- Arbitrary-offset alignment: same stream as the acquisition test with 0–7 leading junk bits -> identical byte sequence for every offset.
- Reset mid-operation: in SYNC, assert `reset` for 1 cycle in the middle of byte 0x77 -> outputs clear immediately. The lane needs a fresh 4×0xBC before `IDL` returns to 1.

Source files
------------

// File: rtl/serial_rx_sync_pkg.sv
// Shared PHY lane definitions: default comma character and the receive FSM states.
package serial_rx_sync_pkg;

  localparam logic [7:0] BC_CHAR_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SYNC   = 2'd2
  } state_t;

endpackage

// File: rtl/serial_rx_sync.sv
// Serial-to-parallel receiver for one PHY lane: comma alignment, sync declaration,
// and byte delivery gated by IDL.
module serial_rx_sync
  import serial_rx_sync_pkg::*;
#(
  parameter logic [7:0]  BC_CHAR    = BC_CHAR_DEFAULT,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       IDL
);

  localparam logic [2:0] LP_SYNC_COUNT = 3'(SYNC_COUNT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_sr, w_nxt;
  logic [2:0] r_bcnt, w_bcnt_nxt;
  logic [2:0] r_ccnt, w_ccnt_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_stb, w_stb_nxt;
  logic       r_idl;
  logic       w_comma;
  logic       w_boundary;

  always_comb begin
    w_nxt       = {r_sr[6:0], data_in};
    w_comma     = (w_nxt == BC_CHAR);
    w_boundary  = (r_bcnt == 3'd7);
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt + 3'd1;
    w_ccnt_nxt  = r_ccnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_stb_nxt   = 1'b0;

    case (r_state)
      ST_SEARCH: begin
        w_bcnt_nxt = r_bcnt;
        if (w_comma) begin
          w_bcnt_nxt  = '0;
          w_ccnt_nxt  = 3'd1;
          w_state_nxt = (LP_SYNC_COUNT == 3'd1) ? ST_SYNC : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        // A failed boundary returns to SEARCH; the window is only re-examined next cycle.
        if (w_boundary) begin
          if (w_comma) begin
            w_ccnt_nxt = r_ccnt + 3'd1;
            if (r_ccnt + 3'd1 == LP_SYNC_COUNT) begin
              w_state_nxt = ST_SYNC;
            end
          end else begin
            w_ccnt_nxt  = '0;
            w_state_nxt = ST_SEARCH;
          end
        end
      end
      ST_SYNC: begin
        if (w_boundary) begin
          w_stb_nxt = 1'b1;
          if (w_comma) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_nxt;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_bcnt_nxt  = '0;
        w_ccnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SEARCH;
      r_sr    <= '0;
      r_bcnt  <= '0;
      r_ccnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_stb   <= 1'b0;
      r_idl   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_stb   <= w_stb_nxt;
      r_idl   <= (w_state_nxt == ST_SYNC);
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign byte_stb  = r_stb;
  assign IDL       = r_idl;

endmodule

// File: tb/tb_serial_rx_sync.sv
// Directed bench for serial_rx_sync: reset, acquisition, abort, interleave, offsets, mid-byte reset.
module tb_serial_rx_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       IDL;

  int checks     = 0;
  int failures   = 0;
  int stb_count  = 0;
  int stray_stb  = 0;

  serial_rx_sync #(
    .BC_CHAR    (8'hBC),
    .SYNC_COUNT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .IDL       (IDL)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
    if (byte_stb === 1'b1) begin
      stb_count++;
      if (IDL !== 1'b1) stray_stb++;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_slot(input string tag, input logic [7:0] exp_data, input logic exp_valid);
    check({tag, "_stb"},   32'(byte_stb),  32'd1);
    check({tag, "_data"},  32'(data_out),  32'(exp_data));
    check({tag, "_valid"}, 32'(valid_out), 32'(exp_valid));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"},  32'(data_out),  32'h00);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_stb"},   32'(byte_stb),  32'd0);
    check({tag, "_idl"},   32'(IDL),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    int s0;

    reset   = 1'b1;
    data_in = 1'b0;
    repeat (4) begin
      data_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check_cleared("rst");
    reset = 1'b0;

    repeat (32) send_bit(1'b0);
    check("zeros_idl", 32'(IDL), 32'd0);
    check("zeros_stb", 32'(stb_count), 32'd0);

    // Acquisition: 3 junk bits, 4 commas, then 0x55.
    repeat (3) send_bit(1'b0);
    repeat (3) send_byte(8'hBC);
    v = 8'hBC;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    check("acq_idl_pre", 32'(IDL), 32'd0);
    send_bit(v[0]);
    check("acq_idl", 32'(IDL), 32'd1);
    check("acq_stb_at_sync", 32'(byte_stb), 32'd0);
    s0 = stb_count;
    v = 8'h55;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    check("acq_no_early_stb", 32'(stb_count - s0), 32'd0);
    send_bit(v[0]);
    check_slot("acq_55", 8'h55, 1'b1);

    // Data/idle interleave.
    send_byte(8'h12);
    check_slot("il_12", 8'h12, 1'b1);
    send_bit(1'b1);
    check("il_stb_one_cycle", 32'(byte_stb), 32'd0);
    v = 8'hBC;
    for (int i = 6; i >= 0; i--) send_bit(v[i]);
    check_slot("il_bc", 8'h12, 1'b0);
    send_byte(8'h34);
    check_slot("il_34", 8'h34, 1'b1);
    s0 = stb_count;
    repeat (5) send_byte(8'h00);
    check("sync_stb_rate", 32'(stb_count - s0), 32'd5);
    check("sync_data_00", 32'(data_out), 32'h00);

    // Reset in the middle of 0x77.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    check("midrst_idl_3bc", 32'(IDL), 32'd0);
    send_byte(8'hBC);
    check("midrst_idl_4bc", 32'(IDL), 32'd1);
    check("midrst_valid", 32'(valid_out), 32'd0);

    // Sync abort: 2 commas, a data byte, then 4 commas.
    do_reset();
    repeat (2) send_byte(8'hBC);
    check("abort_idl_16", 32'(IDL), 32'd0);
    send_byte(8'hA3);
    check("abort_idl_24", 32'(IDL), 32'd0);
    repeat (3) send_byte(8'hBC);
    check("abort_idl_3bc", 32'(IDL), 32'd0);
    send_byte(8'hBC);
    check("abort_idl_4bc", 32'(IDL), 32'd1);
    send_byte(8'h5A);
    check_slot("abort_5a", 8'h5A, 1'b1);

    // Alignment at every bit offset.
    for (int off = 0; off < 8; off++) begin
      do_reset();
      repeat (off) send_bit(1'b1);
      repeat (4) send_byte(8'hBC);
      check($sformatf("off%0d_idl", off), 32'(IDL), 32'd1);
      send_byte(8'h55);
      check_slot($sformatf("off%0d_55", off), 8'h55, 1'b1);
      send_byte(8'h12);
      check_slot($sformatf("off%0d_12", off), 8'h12, 1'b1);
      send_byte(8'hBC);
      check_slot($sformatf("off%0d_bc", off), 8'h12, 1'b0);
      send_byte(8'h34);
      check_slot($sformatf("off%0d_34", off), 8'h34, 1'b1);
    end

    check("stray_stb", 32'(stray_stb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
